// File: rtl/load_unit.sv
// rtl/load_unit.sv - RV32I load unit: req/ack data-memory read, lane extraction, sign/zero extension
// Flags illegal funct3, misaligned addresses and memory timeouts as faulted completions.
module load_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    logic [1:0]  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        req_legal;
    logic        req_misaligned;
    logic [31:0] lane_shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_v;

    always_comb begin
        req_legal = (funct3 == F_LB) || (funct3 == F_LH) || (funct3 == F_LW) ||
                    (funct3 == F_LBU) || (funct3 == F_LHU);
        req_misaligned = 1'b0;
        if ((funct3 == F_LH) || (funct3 == F_LHU)) begin
            req_misaligned = addr[0];
        end else if (funct3 == F_LW) begin
            req_misaligned = (addr[1:0] != 2'b00);
        end
    end

    // Lane selection uses the latched offset/type; mem_rdata only matters on the ack cycle.
    always_comb begin
        lane_shifted = mem_rdata >> {off_q, 3'b000};
        byte_v       = lane_shifted[7:0];
        half_v       = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            F_LB:    ext_v = {{24{byte_v[7]}}, byte_v};
            F_LH:    ext_v = {{16{half_v[15]}}, half_v};
            F_LBU:   ext_v = {24'd0, byte_v};
            F_LHU:   ext_v = {16'd0, half_v};
            default: ext_v = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        mem_addr_d = mem_addr_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    if (!req_legal || req_misaligned) begin
                        state_d = S_ERR;
                    end else begin
                        mem_addr_d = {addr[31:2], 2'b00};
                        wait_cnt_d = 8'd1;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    rdata_d = ext_v;
                    state_d = S_DONE;
                end else if (wait_cnt_q == MAX_W) begin
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            mem_addr_q <= 32'd0;
            rdata_q    <= 32'd0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE) || (state_q == S_ERR);
    assign fault    = (state_q == S_ERR);
    assign mem_req  = (state_q == S_REQ);
    assign mem_addr = mem_addr_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    load_unit #(.MAX_WAIT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .addr     (addr),
        .busy     (busy),
        .done     (done),
        .fault    (fault),
        .rdata    (rdata),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a);
        start  = 1'b1;
        funct3 = f3;
        addr   = a;
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'b111;
        addr   = 32'hFFFF_FFFF;
    endtask

    // Successful load with ack in cycle k; returns at negedge of cycle k+2.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input int k, input logic [31:0] exp,
                           input bit start_at_done);
        issue(f3, a);
        chk({tag, " busy c1"}, 32'(busy), 32'd1);
        for (int i = 1; i < k; i++) begin
            chk({tag, " mem_req wait"}, 32'(mem_req), 32'd1);
            @(negedge clk);
        end
        chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " fault"}, 32'(fault), 32'd0);
        chk({tag, " rdata"}, rdata, exp);
        chk({tag, " mem_req off"}, 32'(mem_req), 32'd0);
        if (start_at_done) begin
            start  = 1'b1;
            funct3 = 3'b011;
            addr   = 32'h0;
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        chk({tag, " done after"}, 32'(done), 32'd0);
    endtask

    task automatic do_fault(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] prev);
        issue(f3, a);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " fault"}, 32'(fault), 32'd1);
        chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " rdata"}, rdata, prev);
        @(negedge clk);
        chk({tag, " idle"}, {30'd0, busy, mem_req}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        funct3    = 3'b000;
        addr      = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_load("lw100", 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0);
        do_load("lb103", 3'b000, 32'h103, 32'h80FF7F01, 1, 32'hFFFFFF80, 1'b0);
        do_load("lbu103", 3'b100, 32'h103, 32'h80FF7F01, 1, 32'h00000080, 1'b0);
        do_load("lb101", 3'b000, 32'h101, 32'h80FF7F01, 1, 32'h0000007F, 1'b0);
        do_load("lh102", 3'b001, 32'h102, 32'h8001FFFF, 1, 32'hFFFF8001, 1'b0);
        do_load("lhu102", 3'b101, 32'h102, 32'h8001FFFF, 1, 32'h00008001, 1'b0);
        do_load("lh100", 3'b001, 32'h100, 32'h8001FFFF, 1, 32'hFFFFFFFF, 1'b0);

        do_fault("lw102", 3'b010, 32'h102, 32'hFFFFFFFF);
        do_fault("lh101", 3'b001, 32'h101, 32'hFFFFFFFF);
        do_fault("f3_011", 3'b011, 32'h100, 32'hFFFFFFFF);

        do_load("ack15", 3'b010, 32'h200, 32'h12345678, 15, 32'h12345678, 1'b0);

        // Timeout with no ack, then a late ack in cycle 17.
        issue(3'b010, 32'h300);
        for (int i = 1; i <= 15; i++) begin
            chk("to mem_req", 32'(mem_req), 32'd1);
            chk("to done early", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("to done", 32'(done), 32'd1);
        chk("to fault", 32'(fault), 32'd1);
        chk("to mem_req drop", 32'(mem_req), 32'd0);
        chk("to rdata", rdata, 32'h12345678);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        chk("to busy c17", 32'(busy), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late ack done", 32'(done), 32'd0);
        chk("late ack rdata", rdata, 32'h12345678);

        // start pulse during REQ is ignored.
        issue(3'b100, 32'h104);
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b010;
        addr   = 32'h400;
        @(negedge clk);
        start = 1'b0;
        chk("midstart mem_addr", mem_addr, 32'h104);
        chk("midstart mem_req", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h000000AB;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("midstart done", 32'(done), 32'd1);
        chk("midstart rdata", rdata, 32'h000000AB);
        @(negedge clk);
        @(negedge clk);
        chk("midstart no 2nd", {30'd0, busy, done}, 32'd0);

        // rst in cycle 3 of a pending access.
        issue(3'b010, 32'h500);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b1;
        chk("rst mid mem_req", 32'(mem_req), 32'd0);
        chk("rst mid done", 32'(done), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst late done", 32'(done), 32'd0);
        chk("rst rdata clr", rdata, 32'd0);

        // start coincident with done is dropped; start right after done is taken.
        do_load("b2b a", 3'b010, 32'h600, 32'h11112222, 2, 32'h11112222, 1'b1);
        do_load("b2b b", 3'b101, 32'h602, 32'hBEEF0000, 1, 32'h0000BEEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
